// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared defines for the IF/ID pipeline register
package if_id_stage_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;

    // Instruction fetches must be word aligned; any low PC bit set is a fault.
    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/stage_reg.sv
// rtl/stage_reg.sv - one pipeline field with reset, clear and load enable
module stage_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register; IF_ID_STALL_CNT_EN adds stall/flush counters
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            flush,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic [XLEN-1:0] instr_out,
    output logic            valid_out,
    output logic            misalign_out
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [XLEN-1:0] stall_cnt,
    output logic [XLEN-1:0] flush_cnt
`endif
);

    logic            capture;
    logic            misalign_d;
    logic [XLEN-1:0] instr_d;

    assign pc_load    = ~stall | flush;
    assign capture    = ~stall & ~flush;
    assign misalign_d = valid_in & is_misaligned(pc_in);
    assign instr_d    = (valid_in && !misalign_d) ? instr_in : NOP_INSTR;

    // PC fields hold across a flush; the instruction-side fields clear to a bubble.
    stage_reg #(.WIDTH(XLEN), .RST_VAL('0)) u_pc (
        .clk(clk), .rst(rst), .clr(1'b0), .en(capture),
        .d(pc_in), .q(pc_out)
    );

    stage_reg #(.WIDTH(XLEN), .RST_VAL(PC_INC)) u_pc_plus4 (
        .clk(clk), .rst(rst), .clr(1'b0), .en(capture),
        .d(pc_in + PC_INC), .q(pc_plus4_out)
    );

    stage_reg #(.WIDTH(XLEN), .RST_VAL(NOP_INSTR)) u_instr (
        .clk(clk), .rst(rst), .clr(flush), .en(capture),
        .d(instr_d), .q(instr_out)
    );

    stage_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
        .clk(clk), .rst(rst), .clr(flush), .en(capture),
        .d(valid_in), .q(valid_out)
    );

    stage_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_misalign (
        .clk(clk), .rst(rst), .clr(flush), .en(capture),
        .d(misalign_d), .q(misalign_out)
    );

`ifdef IF_ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !flush && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized self-checking bench for if_id_stage
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        misalign_out;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    if_id_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .valid_in(valid_in), .stall(stall), .flush(flush), .pc_load(pc_load),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .instr_out(instr_out),
        .valid_out(valid_out), .misalign_out(misalign_out)
`ifdef IF_ID_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] m_pc, m_p4, m_instr;
    logic        m_valid, m_mis;
    longint      m_scnt, m_fcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat_inc(input longint v);
        return (v >= 64'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic cycle(input logic r, input logic s, input logic f,
                         input logic v, input logic [31:0] pc, input logic [31:0] ins);
        @(negedge clk);
        rst = r; stall = s; flush = f; valid_in = v; pc_in = pc; instr_in = ins;
        #1;
        check("pc_load", {31'b0, pc_load}, {31'b0, (!s || f)});
        if (r) begin
            m_pc = 0; m_p4 = 4; m_instr = NOP; m_valid = 0; m_mis = 0;
            m_scnt = 0; m_fcnt = 0;
        end else if (f) begin
            m_valid = 0; m_mis = 0; m_instr = NOP;
            m_fcnt = sat_inc(m_fcnt);
        end else if (s) begin
            m_scnt = sat_inc(m_scnt);
        end else begin
            m_pc    = pc;
            m_p4    = 32'((64'(pc) + 4) % 64'h1_0000_0000);
            m_valid = v;
            if (!v) begin
                m_instr = NOP; m_mis = 0;
            end else if (pc % 4 != 0) begin
                m_instr = NOP; m_mis = 1;
            end else begin
                m_instr = ins; m_mis = 0;
            end
        end
        @(posedge clk);
        #1;
        check("pc_out", pc_out, m_pc);
        check("pc_plus4_out", pc_plus4_out, m_p4);
        check("instr_out", instr_out, m_instr);
        check("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
        check("misalign_out", {31'b0, misalign_out}, {31'b0, m_mis});
`ifdef IF_ID_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'(m_scnt));
        check("flush_cnt", flush_cnt, 32'(m_fcnt));
`endif
    endtask

    initial begin
        logic [31:0] rpc;
        rst = 1; stall = 0; flush = 0; valid_in = 0; pc_in = 0; instr_in = 0;
        m_pc = 0; m_p4 = 4; m_instr = NOP; m_valid = 0; m_mis = 0; m_scnt = 0; m_fcnt = 0;

        // reset for two cycles
        cycle(1, 0, 0, 0, 32'h0, 32'h0);
        cycle(1, 0, 0, 1, 32'h40, 32'hDEAD_BEEF);
        // basic capture
        cycle(0, 0, 0, 1, 32'h100, 32'h0050_0093);
        // three-cycle stall with changing inputs, then capture
        cycle(0, 1, 0, 1, 32'h104, 32'h1111_1111);
        cycle(0, 1, 0, 0, 32'h108, 32'h2222_2222);
        cycle(0, 1, 0, 1, 32'h10C, 32'h3333_3333);
        cycle(0, 0, 0, 1, 32'h110, 32'h4444_4444);
        // stall and flush together
        cycle(0, 1, 1, 1, 32'h114, 32'h5555_5555);
        // misaligned fetch and PC wrap
        cycle(0, 0, 0, 1, 32'h102, 32'h6666_6666);
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h7777_7777);
        cycle(0, 0, 0, 0, 32'h200, 32'h8888_8888);
        // reset during a stall, then resume
        cycle(0, 1, 0, 1, 32'h300, 32'h9999_9999);
        cycle(1, 1, 0, 1, 32'h304, 32'hAAAA_AAAA);
        cycle(0, 1, 0, 1, 32'h308, 32'hBBBB_BBBB);
        cycle(0, 0, 0, 1, 32'h30C, 32'hCCCC_CCCC);

        for (int i = 0; i < 400; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) != 0),
                  rpc, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
